// File: rtl/dtw_pkg.sv
// Shared types and field layout for the DTW backtrace path writer.
package dtw_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_TRAILER
  } wr_state_e;

  localparam int DTW_LEN_W   = 7;
  localparam int DTW_SCORE_W = 16;

  // Trailer word: {9'b0, len[6:0], score[15:0]}
  localparam int TRL_SCORE_LSB = 0;
  localparam int TRL_LEN_LSB   = 16;

  // Backtrace word: {3'b0, tidx[4:0], 3'b0, ridx[4:0], score[15:0]}
  localparam int BT_IDX_W      = 5;
  localparam int BT_SCORE_LSB  = 0;
  localparam int BT_RIDX_LSB   = 16;
  localparam int BT_TIDX_LSB   = 24;

  function automatic logic [31:0] pack_trailer(input logic [DTW_LEN_W-1:0]   len,
                                               input logic [DTW_SCORE_W-1:0] score);
    logic [31:0] w;
    w = '0;
    w[TRL_LEN_LSB   +: DTW_LEN_W]   = len;
    w[TRL_SCORE_LSB +: DTW_SCORE_W] = score;
    return w;
  endfunction

endpackage

// File: rtl/dtw_wr_fifo.sv
// Small synchronous FIFO buffering backtrace words ahead of the SRAM port.
module dtw_wr_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_one
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [AW:0]      r_cnt;
  logic             w_push, w_pop;

  assign o_full  = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_one   = (r_cnt == (AW+1)'(1));
  assign o_rdata = r_mem[r_rp];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      if (w_push & ~w_pop)      r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop & ~w_push) r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_wdata;
  end

endmodule

// File: rtl/dtw_path_writer.sv
// Buffers the backtrace word stream and writes it to the result SRAM, then a
// trailer {len, score} at the frame base address.
module dtw_path_writer
  import dtw_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              i_bt_start,
  input  logic              i_bt_end,
  input  logic [31:0]       i_data,
  input  logic              i_sram_gnt,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [31:0]       o_sram_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic [6:0]        o_len,
  output logic              o_err
);

  localparam logic [ADDR_W-1:0] L_BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] L_FIRST = L_BASE + ADDR_W'(1);

  wr_state_e               r_state, w_nxt;
  logic                    r_start_q;
  logic [ADDR_W-1:0]       r_ptr;
  logic [DTW_LEN_W-1:0]    r_len, w_len_base, w_len_nxt;
  logic [DTW_SCORE_W-1:0]  r_score;
  logic                    r_err, r_done;

  logic        w_frame_start, w_push_req, w_push_ok, w_drop, w_trunc;
  logic        w_fifo_we, w_pop, w_trl_we;
  logic        w_full, w_empty, w_one;
  logic [31:0] w_head;

  dtw_wr_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .nrst    (nrst),
    .i_push  (w_push_req),
    .i_wdata (i_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_one   (w_one)
  );

  always_comb begin
    w_frame_start = (r_state == ST_IDLE) & i_bt_start & ~r_start_q;
    w_push_req    = w_frame_start | ((r_state == ST_RUN) & i_bt_start);
    w_fifo_we     = ((r_state == ST_RUN) | (r_state == ST_DRAIN)) & ~w_empty;
    w_pop         = w_fifo_we & i_sram_gnt;
    w_push_ok     = w_push_req & (~w_full | w_pop);
    w_drop        = w_push_req & ~w_push_ok;
    w_trunc       = (r_state == ST_RUN) & ~i_bt_start;
    w_trl_we      = (r_state == ST_TRAILER);

    w_len_base = w_frame_start ? '0 : r_len;
    w_len_nxt  = w_len_base;
    if (w_push_ok && (w_len_base != '1)) w_len_nxt = w_len_base + DTW_LEN_W'(1);

    w_nxt = r_state;
    case (r_state)
      ST_IDLE:    if (w_frame_start) w_nxt = i_bt_end ? ST_DRAIN : ST_RUN;
      ST_RUN:     if (!i_bt_start || i_bt_end) w_nxt = ST_DRAIN;
      // Leave once the FIFO is (or is about to be) empty so the trailer follows the last word.
      ST_DRAIN:   if (w_empty || (w_one && w_pop)) w_nxt = ST_TRAILER;
      ST_TRAILER: if (i_sram_gnt) w_nxt = ST_IDLE;
      default:    w_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= ST_IDLE;
      r_start_q <= 1'b0;
      r_ptr     <= L_FIRST;
      r_len     <= '0;
      r_score   <= '0;
      r_err     <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_start_q <= i_bt_start;
      r_len     <= w_len_nxt;
      r_done    <= w_trl_we & i_sram_gnt;
      r_err     <= (w_frame_start ? 1'b0 : r_err) | w_drop | w_trunc;
      if (w_push_ok) r_score <= i_data[BT_SCORE_LSB +: DTW_SCORE_W];
      if (w_frame_start) r_ptr <= L_FIRST;
      else if (w_pop)    r_ptr <= r_ptr + ADDR_W'(1);
    end
  end

  // SRAM outputs are muxes of flops only; no input-to-output combinational path.
  assign o_sram_we    = w_fifo_we | w_trl_we;
  assign o_sram_addr  = w_trl_we ? L_BASE : (w_fifo_we ? r_ptr : '0);
  assign o_sram_wdata = w_trl_we ? pack_trailer(r_len, r_score) : (w_fifo_we ? w_head : '0);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_done       = r_done;
  assign o_len        = r_len;
  assign o_err        = r_err;

endmodule

// File: tb/tb_dtw_path_writer.sv
// Directed frame-level bench for dtw_path_writer: default instance plus a
// small-address instance for pointer wrap.
module tb_dtw_path_writer;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        bt_start = 1'b0, bt_end = 1'b0, gnt = 1'b1;
  logic [31:0] data = '0;

  logic        a_we, a_busy, a_done, a_err;
  logic [9:0]  a_addr;
  logic [31:0] a_wdata;
  logic [6:0]  a_len;
  logic        w_we, w_busy, w_done, w_err;
  logic [3:0]  w_addr;
  logic [31:0] w_wdata;
  logic [6:0]  w_len;

  always #5 clk = ~clk;

  dtw_path_writer u_a (
    .clk(clk), .nrst(nrst), .i_bt_start(bt_start), .i_bt_end(bt_end), .i_data(data),
    .i_sram_gnt(gnt), .o_sram_we(a_we), .o_sram_addr(a_addr), .o_sram_wdata(a_wdata),
    .o_busy(a_busy), .o_done(a_done), .o_len(a_len), .o_err(a_err));

  dtw_path_writer #(.ADDR_W(4), .FIFO_DEPTH(8), .BASE_ADDR(14)) u_w (
    .clk(clk), .nrst(nrst), .i_bt_start(bt_start), .i_bt_end(bt_end), .i_data(data),
    .i_sram_gnt(gnt), .o_sram_we(w_we), .o_sram_addr(w_addr), .o_sram_wdata(w_wdata),
    .o_busy(w_busy), .o_done(w_done), .o_len(w_len), .o_err(w_err));

  logic [9:0]  aq_addr [$];
  logic [31:0] aq_data [$];
  logic [3:0]  wq_addr [$];
  logic [31:0] wq_data [$];
  int          n_done_a, n_done_w;
  int          checks = 0, errors = 0;

  always @(negedge clk) begin
    if (nrst) begin
      if (a_we && gnt) begin aq_addr.push_back(a_addr); aq_data.push_back(a_wdata); end
      if (w_we && gnt) begin wq_addr.push_back(w_addr); wq_data.push_back(w_wdata); end
      if (a_done) n_done_a++;
      if (w_done) n_done_w++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] word(input int i, input logic [15:0] sb);
    logic [4:0] t;
    t = 5'(i);
    return {3'b0, t, 3'b0, ~t, sb + 16'(i)};
  endfunction

  task automatic clear_logs();
    aq_addr.delete(); aq_data.delete();
    wq_addr.delete(); wq_data.delete();
    n_done_a = 0; n_done_w = 0;
  endtask

  // Drives one frame: nw words, grant low for cycles [g0, g0+gn), then waits for o_done.
  task automatic run_frame(input int nw, input bit trunc, input logic [15:0] sb,
                           input int g0, input int gn);
    int t;
    clear_logs();
    for (int c = 0; c < nw; c++) begin
      bt_start = 1'b1;
      data     = word(c, sb);
      bt_end   = !trunc && (c == nw - 1);
      gnt      = !(c >= g0 && c < g0 + gn);
      tick();
    end
    bt_start = 1'b0; bt_end = 1'b0; gnt = 1'b1; data = '0;
    t = 0;
    while (n_done_a == 0 && t < 300) begin tick(); t++; end
    if (n_done_a == 0) begin
      checks++; errors++;
      $display("FAIL done_timeout: got no o_done expected a pulse within 300 cycles");
    end
    repeat (4) tick();
  endtask

  typedef struct {
    int          nw;
    bit          trunc;
    logic [15:0] sb;
    int          g0;
    int          gn;
    int          exp_paths;
    int          exp_len;
    bit          exp_err;
  } vec_t;

  vec_t tv [6];

  initial begin
    tv[0] = '{5,   1'b0, 16'h019F, 0, 0,  5,   5,   1'b0}; // basic
    tv[1] = '{6,   1'b0, 16'h1000, 1, 4,  6,   6,   1'b0}; // back-pressure
    tv[2] = '{12,  1'b0, 16'h2000, 0, 12, 8,   8,   1'b1}; // overflow
    tv[3] = '{3,   1'b1, 16'h3000, 0, 0,  3,   3,   1'b1}; // truncated
    tv[4] = '{1,   1'b0, 16'h4000, 0, 0,  1,   1,   1'b0}; // one-word
    tv[5] = '{130, 1'b0, 16'h5000, 0, 0,  130, 127, 1'b0}; // length saturation

    #2;
    chk("rst_we", a_we, 0);     chk("rst_addr", a_addr, 0);  chk("rst_wdata", a_wdata, 0);
    chk("rst_busy", a_busy, 0); chk("rst_done", a_done, 0);  chk("rst_len", a_len, 0);
    chk("rst_err", a_err, 0);
    tick(); nrst = 1'b1; tick(); tick();

    for (int v = 0; v < 6; v++) begin
      run_frame(tv[v].nw, tv[v].trunc, tv[v].sb, tv[v].g0, tv[v].gn);
      chk($sformatf("v%0d_nwr", v), aq_addr.size(), tv[v].exp_paths + 1);
      if (aq_addr.size() == tv[v].exp_paths + 1) begin
        for (int i = 0; i < tv[v].exp_paths; i++) begin
          chk($sformatf("v%0d_addr%0d", v, i), aq_addr[i], i + 1);
          chk($sformatf("v%0d_data%0d", v, i), aq_data[i], word(i, tv[v].sb));
        end
        chk($sformatf("v%0d_trl_addr", v), aq_addr[tv[v].exp_paths], 0);
        chk($sformatf("v%0d_trl_data", v), aq_data[tv[v].exp_paths],
            {9'b0, 7'(tv[v].exp_len), tv[v].sb + 16'(tv[v].exp_paths - 1)});
      end
      chk($sformatf("v%0d_done_cnt", v), n_done_a, 1);
      chk($sformatf("v%0d_len", v), a_len, tv[v].exp_len);
      chk($sformatf("v%0d_err", v), a_err, tv[v].exp_err);
      chk($sformatf("v%0d_busy", v), a_busy, 0);
      if (v == 0 && aq_data.size() == 6) chk("basic_trailer_word", aq_data[5], 32'h000501A3);
    end

    // Pointer wrap on the 4-bit instance: path at 15, 0, 1 then trailer at 14.
    run_frame(3, 1'b0, 16'h6000, 0, 0);
    chk("wrap_nwr", wq_addr.size(), 4);
    if (wq_addr.size() == 4) begin
      chk("wrap_a0", wq_addr[0], 15); chk("wrap_a1", wq_addr[1], 0);
      chk("wrap_a2", wq_addr[2], 1);  chk("wrap_trl_a", wq_addr[3], 14);
      chk("wrap_d1", wq_data[1], word(1, 16'h6000));
      chk("wrap_trl_d", wq_data[3], 32'h00036002);
    end
    chk("wrap_done_cnt", n_done_w, 1);

    // Reset mid-RUN with three words held back by a low grant.
    clear_logs();
    for (int c = 0; c < 3; c++) begin
      bt_start = 1'b1; bt_end = 1'b0; gnt = 1'b0; data = word(c, 16'h7000);
      tick();
    end
    chk("pre_rst_busy", a_busy, 1);
    chk("pre_rst_len", a_len, 3);
    nrst = 1'b0; bt_start = 1'b0; gnt = 1'b1;
    #1;
    chk("mid_rst_we", a_we, 0);     chk("mid_rst_addr", a_addr, 0);
    chk("mid_rst_wdata", a_wdata, 0); chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_len", a_len, 0);   chk("mid_rst_err", a_err, 0);
    tick(); tick(); nrst = 1'b1;
    repeat (10) tick();
    chk("post_rst_writes", aq_addr.size(), 0);
    chk("post_rst_done", n_done_a, 0);
    chk("post_rst_busy", a_busy, 0);

    // Frame after reset starts cleanly at BASE_ADDR+1.
    run_frame(2, 1'b0, 16'h8000, 0, 0);
    chk("after_rst_nwr", aq_addr.size(), 3);
    if (aq_addr.size() == 3) begin
      chk("after_rst_a0", aq_addr[0], 1);
      chk("after_rst_trl", aq_data[2], 32'h00028001);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
